// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register for the 5-stage MIPS core: captures decoded fields,
// forwards EXE/MEM and MEM/WB results into the ALU operands, and detects load-use.
module id_exe_stage #(
   parameter int WIDTH = 32,
   parameter int RA    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [3:0]       id_cmd,
   input  logic [WIDTH-1:0] id_val1,
   input  logic [WIDTH-1:0] id_val2,
   input  logic [WIDTH-1:0] id_imm,
   input  logic             id_use_imm,
   input  logic [RA-1:0]    id_src1,
   input  logic [RA-1:0]    id_src2,
   input  logic             id_src2_used,
   input  logic [RA-1:0]    id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             mem_wb_en,
   input  logic [RA-1:0]    mem_dest,
   input  logic [WIDTH-1:0] mem_result,
   input  logic             wb_wb_en,
   input  logic [RA-1:0]    wb_dest,
   input  logic [WIDTH-1:0] wb_value,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_cmd,
   output logic [WIDTH-1:0] exe_st_val,
   output logic [RA-1:0]    exe_dest,
   output logic             exe_wb_en,
   output logic             exe_mem_read,
   output logic             exe_mem_write,
   output logic             exe_valid,
   output logic             stall
);

   logic [WIDTH-1:0] ex_val1;
   logic [WIDTH-1:0] ex_val2;
   logic [WIDTH-1:0] ex_imm;
   logic             ex_use_imm;
   logic [RA-1:0]    ex_src1;
   logic [RA-1:0]    ex_src2;
   logic [WIDTH-1:0] fwd1;
   logic [WIDTH-1:0] fwd2;
   logic             bubble;

   // stall is a one-cycle hold request to IF/ID: while it is high this stage loads
   // a bubble, and upstream re-presents the same ID fields on the following cycle.
   assign stall = exe_valid & exe_mem_read & (exe_dest != '0) & id_valid & ~flush &
                  ((id_src1 == exe_dest) | (id_src2_used & (id_src2 == exe_dest)));

   assign bubble = flush | stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_valid     <= 1'b0;
         alu_cmd       <= '0;
         ex_val1       <= '0;
         ex_val2       <= '0;
         ex_imm        <= '0;
         ex_use_imm    <= 1'b0;
         ex_src1       <= '0;
         ex_src2       <= '0;
         exe_dest      <= '0;
         exe_wb_en     <= 1'b0;
         exe_mem_read  <= 1'b0;
         exe_mem_write <= 1'b0;
      end else if (bubble) begin
         exe_valid     <= 1'b0;
         alu_cmd       <= '0;
         ex_val1       <= '0;
         ex_val2       <= '0;
         ex_imm        <= '0;
         ex_use_imm    <= 1'b0;
         ex_src1       <= '0;
         ex_src2       <= '0;
         exe_dest      <= '0;
         exe_wb_en     <= 1'b0;
         exe_mem_read  <= 1'b0;
         exe_mem_write <= 1'b0;
      end else begin
         exe_valid     <= id_valid;
         alu_cmd       <= id_cmd;
         ex_val1       <= id_val1;
         ex_val2       <= id_val2;
         ex_imm        <= id_imm;
         ex_use_imm    <= id_use_imm;
         ex_src1       <= id_src1;
         ex_src2       <= id_src2;
         exe_dest      <= id_dest;
         exe_wb_en     <= id_wb_en;
         exe_mem_read  <= id_mem_read;
         exe_mem_write <= id_mem_write;
      end
   end

   // EXE/MEM is the younger producer, so it wins over MEM/WB; r0 is hardwired zero.
   always_comb begin
      fwd1 = ex_val1;
      if (mem_wb_en && (mem_dest == ex_src1) && (ex_src1 != '0))
         fwd1 = mem_result;
      else if (wb_wb_en && (wb_dest == ex_src1) && (ex_src1 != '0))
         fwd1 = wb_value;
   end

   always_comb begin
      fwd2 = ex_val2;
      if (mem_wb_en && (mem_dest == ex_src2) && (ex_src2 != '0))
         fwd2 = mem_result;
      else if (wb_wb_en && (wb_dest == ex_src2) && (ex_src2 != '0))
         fwd2 = wb_value;
   end

   always_comb begin
      alu_in1    = '0;
      alu_in2    = '0;
      exe_st_val = '0;
      if (exe_valid) begin
         alu_in1    = fwd1;
         exe_st_val = fwd2;
         alu_in2    = ex_use_imm ? ex_imm : fwd2;
      end
   end

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: directed vector table, hand-written
// reset/load-use/flush sequences, then random traffic against a reference model.
module tb_id_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic [3:0]  id_cmd;
   logic [31:0] id_val1, id_val2, id_imm;
   logic        id_use_imm;
   logic [4:0]  id_src1, id_src2, id_dest;
   logic        id_src2_used, id_wb_en, id_mem_read, id_mem_write;
   logic        mem_wb_en, wb_wb_en;
   logic [4:0]  mem_dest, wb_dest;
   logic [31:0] mem_result, wb_value;
   logic [31:0] alu_in1, alu_in2, exe_st_val;
   logic [3:0]  alu_cmd;
   logic [4:0]  exe_dest;
   logic        exe_wb_en, exe_mem_read, exe_mem_write, exe_valid, stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_exe_stage #(.WIDTH(32), .RA(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_cmd(id_cmd), .id_val1(id_val1), .id_val2(id_val2),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_src1(id_src1), .id_src2(id_src2),
      .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
      .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd), .exe_st_val(exe_st_val),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
      .exe_mem_write(exe_mem_write), .exe_valid(exe_valid), .stall(stall)
   );

   // reference model: the instruction currently occupying EXE
   typedef struct {
      logic        valid;
      logic [3:0]  cmd;
      logic [31:0] v1, v2, imm;
      logic        ui;
      logic [4:0]  s1, s2, dest;
      logic        wb, mr, mw;
   } exe_t;

   exe_t m;

   function automatic exe_t empty_exe();
      exe_t e;
      e.valid = 0; e.cmd = 0; e.v1 = 0; e.v2 = 0; e.imm = 0; e.ui = 0;
      e.s1 = 0; e.s2 = 0; e.dest = 0; e.wb = 0; e.mr = 0; e.mw = 0;
      return e;
   endfunction

   // a load in EXE whose result the instruction in ID needs cannot be forwarded in time
   function automatic logic model_stall();
      logic needs;
      needs = (id_src1 == m.dest) || (id_src2_used && id_src2 == m.dest);
      return !flush && m.valid && m.mr && m.dest != 0 && id_valid && needs;
   endfunction

   // newest in-flight producer of a register supplies its value
   function automatic logic [31:0] model_operand(input logic [4:0] src, input logic [31:0] rf);
      if (src == 0) return rf;
      if (mem_wb_en && mem_dest == src) return mem_result;
      if (wb_wb_en && wb_dest == src) return wb_value;
      return rf;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e1, e2, es;
      e1 = 0; e2 = 0; es = 0;
      if (m.valid) begin
         e1 = model_operand(m.s1, m.v1);
         es = model_operand(m.s2, m.v2);
         e2 = m.ui ? m.imm : es;
      end
      chk({tag, ".in1"}, alu_in1, e1);
      chk({tag, ".in2"}, alu_in2, e2);
      chk({tag, ".st"}, exe_st_val, es);
      chk({tag, ".cmd"}, {28'd0, alu_cmd}, {28'd0, m.cmd});
      chk({tag, ".ctl"}, {27'd0, exe_valid, exe_wb_en, exe_mem_read, exe_mem_write, 1'b0},
          {27'd0, m.valid, m.wb, m.mr, m.mw, 1'b0});
      chk({tag, ".dest"}, {27'd0, exe_dest}, {27'd0, m.dest});
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, model_stall()});
   endtask

   // one rising edge; the model captures the same inputs the DUT sampled
   task automatic tick();
      @(posedge clk);
      if (rst) m = empty_exe();
      else if (flush || model_stall()) m = empty_exe();
      else begin
         m.valid = id_valid; m.cmd = id_cmd; m.v1 = id_val1; m.v2 = id_val2;
         m.imm = id_imm; m.ui = id_use_imm; m.s1 = id_src1; m.s2 = id_src2;
         m.dest = id_dest; m.wb = id_wb_en; m.mr = id_mem_read; m.mw = id_mem_write;
      end
      #1;
   endtask

   task automatic set_id(input logic vld, input logic [3:0] cmd, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] imm, input logic ui,
                         input logic [4:0] s1, input logic [4:0] s2, input logic s2u,
                         input logic [4:0] dest, input logic wb, input logic mr,
                         input logic mw);
      id_valid = vld; id_cmd = cmd; id_val1 = v1; id_val2 = v2; id_imm = imm;
      id_use_imm = ui; id_src1 = s1; id_src2 = s2; id_src2_used = s2u;
      id_dest = dest; id_wb_en = wb; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic set_fw(input logic me, input logic [4:0] md, input logic [31:0] mr,
                         input logic we, input logic [4:0] wd, input logic [31:0] wv);
      mem_wb_en = me; mem_dest = md; mem_result = mr;
      wb_wb_en = we; wb_dest = wd; wb_value = wv;
   endtask

   typedef struct {
      logic        vld;
      logic [3:0]  cmd;
      logic [31:0] v1, v2, imm;
      logic        ui;
      logic [4:0]  s1, s2, dest;
      logic        me;
      logic [4:0]  md;
      logic [31:0] mr;
      logic        we;
      logic [4:0]  wd;
      logic [31:0] wv;
      logic [31:0] e1, e2, es;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1, 4'h0, 32'd5, 32'd7, 32'd0, 0, 5'd1, 5'd2, 5'd3,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'd5, 32'd7, 32'd7};
      vecs[1] = '{1, 4'h2, 32'h11, 32'h22, 32'd0, 0, 5'd3, 5'd6, 5'd5,
                  1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB, 32'hAAAA, 32'h22, 32'h22};
      vecs[2] = '{1, 4'h2, 32'h11, 32'h22, 32'd0, 0, 5'd3, 5'd6, 5'd5,
                  0, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB, 32'hBBBB, 32'h22, 32'h22};
      vecs[3] = '{1, 4'h3, 32'h11, 32'h22, 32'd0, 0, 5'd0, 5'd6, 5'd5,
                  1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB, 32'h11, 32'h22, 32'h22};
      vecs[4] = '{1, 4'h4, 32'd3, 32'h99, 32'h10, 1, 5'd1, 5'd9, 5'd5,
                  1, 5'd9, 32'h55, 0, 5'd0, 32'h0, 32'd3, 32'h10, 32'h55};
      vecs[5] = '{1, 4'h5, 32'd1, 32'd2, 32'd0, 0, 5'd2, 5'd7, 5'd5,
                  1, 5'd8, 32'h66, 1, 5'd7, 32'h77, 32'd1, 32'h77, 32'h77};
      vecs[6] = '{1, 4'h6, 32'h100, 32'h200, 32'd0, 0, 5'd4, 5'd5, 5'd6,
                  1, 5'd5, 32'hAA, 0, 5'd4, 32'hBB, 32'h100, 32'hAA, 32'hAA};
      vecs[7] = '{1, 4'h7, 32'h400, 32'h300, 32'd0, 0, 5'd8, 5'd0, 5'd6,
                  1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 32'h400, 32'h300, 32'h300};
      vecs[8] = '{0, 4'h0, 32'd5, 32'd0, 32'd0, 0, 5'd1, 5'd0, 5'd0,
                  1, 5'd1, 32'hCC, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[9] = '{1, 4'hF, 32'd1, 32'd2, 32'hFFFFFFFF, 1, 5'd1, 5'd2, 5'd7,
                  1, 5'd1, 32'hDEAD, 1, 5'd1, 32'hBEEF, 32'hDEAD, 32'hFFFFFFFF, 32'd2};
   end

   logic held;

   initial begin
      m = empty_exe();
      rst = 1; flush = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_fw(0, 0, 0, 0, 0, 0);
      tick(); tick();
      rst = 0;
      #1;
      chk("reset.valid", {31'd0, exe_valid}, 32'd0);
      chk("reset.in1", alu_in1, 32'd0);

      // reset asserted mid-stall: outputs clear before the next edge
      set_id(1, 4'h1, 32'h40, 0, 0, 0, 5'd1, 5'd0, 0, 5'd4, 1, 1, 0);
      tick();
      set_id(1, 4'h2, 32'h9, 32'h3, 0, 0, 5'd4, 5'd2, 1, 5'd6, 1, 0, 0);
      #1;
      chk("rst_stall.pre", {31'd0, stall}, 32'd1);
      #2 rst = 1; m = empty_exe();
      #1;
      chk("rst_async.stall", {31'd0, stall}, 32'd0);
      chk("rst_async.valid", {31'd0, exe_valid}, 32'd0);
      chk("rst_async.rd", {27'd0, exe_dest}, 32'd0);
      chk("rst_async.ctl", {29'd0, exe_wb_en, exe_mem_read, alu_cmd != 0}, 32'd0);
      tick();
      rst = 0;

      // directed vectors: issue, then observe with forwarding sources applied
      for (int i = 0; i < 10; i++) begin
         set_id(vecs[i].vld, vecs[i].cmd, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].ui,
                vecs[i].s1, vecs[i].s2, 1, vecs[i].dest, 1, 0, 0);
         set_fw(0, 0, 0, 0, 0, 0);
         tick();
         set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         set_fw(vecs[i].me, vecs[i].md, vecs[i].mr, vecs[i].we, vecs[i].wd, vecs[i].wv);
         #1;
         chk($sformatf("vec%0d.in1", i), alu_in1, vecs[i].e1);
         chk($sformatf("vec%0d.in2", i), alu_in2, vecs[i].e2);
         chk($sformatf("vec%0d.st", i), exe_st_val, vecs[i].es);
         chk($sformatf("vec%0d.valid", i), {31'd0, exe_valid}, {31'd0, vecs[i].vld});
         chk($sformatf("vec%0d.cmd", i), {28'd0, alu_cmd}, {28'd0, vecs[i].cmd});
         chk($sformatf("vec%0d.dest", i), {27'd0, exe_dest}, {27'd0, vecs[i].dest});
      end

      // load-use: one bubble, then the load value arrives from MEM/WB
      set_fw(0, 0, 0, 0, 0, 0);
      set_id(1, 4'h1, 32'h40, 0, 0, 0, 5'd1, 5'd0, 0, 5'd4, 1, 1, 0);
      tick();
      set_id(1, 4'h2, 32'h0, 32'h3, 0, 0, 5'd4, 5'd2, 1, 5'd6, 1, 0, 0);
      #1;
      chk("lu.stall", {31'd0, stall}, 32'd1);
      tick();
      chk("lu.bubble_valid", {31'd0, exe_valid}, 32'd0);
      chk("lu.stall_drop", {31'd0, stall}, 32'd0);
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_fw(0, 5'd0, 32'h0, 1, 5'd4, 32'h1234);
      #1;
      chk("lu.consumer_valid", {31'd0, exe_valid}, 32'd1);
      chk("lu.consumer_in1", alu_in1, 32'h1234);

      // flush during a load-use hazard: stall suppressed, single bubble
      set_fw(0, 0, 0, 0, 0, 0);
      set_id(1, 4'h1, 32'h40, 0, 0, 0, 5'd1, 5'd0, 0, 5'd4, 1, 1, 0);
      tick();
      set_id(1, 4'h2, 32'h0, 32'h3, 0, 0, 5'd4, 5'd2, 1, 5'd6, 1, 0, 0);
      flush = 1;
      #1;
      chk("fl.stall", {31'd0, stall}, 32'd0);
      tick();
      flush = 0;
      set_id(1, 4'h3, 32'h8, 32'h9, 0, 0, 5'd1, 5'd2, 1, 5'd7, 1, 0, 0);
      #1;
      chk("fl.bubble_valid", {31'd0, exe_valid}, 32'd0);
      chk("fl.no_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("fl.next_valid", {31'd0, exe_valid}, 32'd1);
      chk("fl.next_in1", alu_in1, 32'h8);

      // random traffic against the reference model
      held = 0;
      for (int c = 0; c < 400; c++) begin
         held = model_stall();
         tick();
         if (!held)
            set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                   $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         flush = $urandom_range(0, 9) == 0;
         set_fw(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         #1;
         check_model($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
